encryption_core: RTL and testbench

ENCRYPTION_CORE -- requirements
Module: encryption_core

---
 rtl/encryption_core.sv | 174 +++++++++++++++++
 tb/tb_encryption_core.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/encryption_core.sv
// AES-128 encryption core: iterative, one full round per clock, with the round
// key schedule computed on the fly alongside the state.
module encryption_core (
    input  logic         clock,
    input  logic         resetModule,
    input  logic [127:0] inputData,
    input  logic [127:0] key,
    input  logic         inputsLoadedFlag,
    output logic [127:0] outputData,
    output logic         dataEncryptedFlag
);

    typedef enum logic [1:0] {
        IDLE,
        ROUND,
        DONE
    } stateType;

    // Forward S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX_TABLE[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    stateType         currentState;
    stateType         nextState;
    logic [15:0][7:0] stateReg;
    logic [127:0]     roundKey;
    logic [3:0]       roundCount;

    logic [15:0][7:0] shifted;
    logic [15:0][7:0] mixed;
    logic [127:0]     nextKey;
    logic [127:0]     roundResult;
    logic [31:0]      keyTemp;
    logic [7:0]       rcon;
    logic             loadInputs;
    logic             doRound;
    logic             finishRound;
    logic             clearFlag;

    // Byte n of the block lives at stateReg[15-n]; bytes are column-major.
    for (genvar c = 0; c < 4; c++) begin : gColumn
        logic [7:0] a0, a1, a2, a3;

        for (genvar r = 0; r < 4; r++) begin : gRow
            assign shifted[15-(4*c+r)] = sbox(stateReg[15-(4*((c+r)%4)+r)]);
        end

        assign a0 = shifted[15-4*c];
        assign a1 = shifted[14-4*c];
        assign a2 = shifted[13-4*c];
        assign a3 = shifted[12-4*c];

        assign mixed[15-4*c] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        assign mixed[14-4*c] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        assign mixed[13-4*c] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        assign mixed[12-4*c] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end

    always_comb begin
        rcon = 8'h00;
        case (roundCount)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    // RotWord + SubWord on the last word, then the chained word XORs.
    assign keyTemp = {sbox(roundKey[23:16]), sbox(roundKey[15:8]),
                      sbox(roundKey[7:0]), sbox(roundKey[31:24])} ^ {rcon, 24'h000000};
    assign nextKey[127:96] = roundKey[127:96] ^ keyTemp;
    assign nextKey[95:64]  = roundKey[95:64]  ^ nextKey[127:96];
    assign nextKey[63:32]  = roundKey[63:32]  ^ nextKey[95:64];
    assign nextKey[31:0]   = roundKey[31:0]   ^ nextKey[63:32];

    assign roundResult = ((roundCount == 4'd10) ? shifted : mixed) ^ nextKey;

    always_ff @(posedge clock) begin
        if (resetModule) begin
            currentState <= IDLE;
        end else begin
            currentState <= nextState;
        end
    end

    always_comb begin
        nextState   = currentState;
        loadInputs  = 1'b0;
        doRound     = 1'b0;
        finishRound = 1'b0;
        clearFlag   = 1'b0;
        case (currentState)
            IDLE: begin
                if (inputsLoadedFlag) begin
                    loadInputs = 1'b1;
                    nextState  = ROUND;
                end
            end
            ROUND: begin
                doRound = 1'b1;
                if (roundCount == 4'd10) begin
                    finishRound = 1'b1;
                    nextState   = DONE;
                end
            end
            DONE: begin
                if (!inputsLoadedFlag) begin
                    clearFlag = 1'b1;
                    nextState = IDLE;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // The counter parks at 10 after the last round and is reloaded on capture.
    always_ff @(posedge clock) begin
        if (resetModule) begin
            stateReg          <= '0;
            roundKey          <= '0;
            roundCount        <= 4'd0;
            outputData        <= '0;
            dataEncryptedFlag <= 1'b0;
        end else if (loadInputs) begin
            stateReg   <= inputData ^ key;
            roundKey   <= key;
            roundCount <= 4'd1;
        end else if (doRound) begin
            stateReg <= roundResult;
            roundKey <= nextKey;
            if (finishRound) begin
                outputData        <= roundResult;
                dataEncryptedFlag <= 1'b1;
            end else begin
                roundCount <= roundCount + 4'd1;
            end
        end else if (clearFlag) begin
            dataEncryptedFlag <= 1'b0;
        end
    end

endmodule

// File: tb/tb_encryption_core.sv
// Bench for encryption_core: FIPS-197 vectors plus random blocks checked
// against a byte-level AES model whose S-box is derived from GF(2^8) inverses.
module tb_encryption_core;

    localparam logic [127:0] C1_KEY   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] B_KEY    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT     = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT     = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] ALL_ONES = {128{1'b1}};

    logic         clock;
    logic         resetModule;
    logic [127:0] inputData;
    logic [127:0] key;
    logic         inputsLoadedFlag;
    logic [127:0] outputData;
    logic         dataEncryptedFlag;

    int assertionCount = 0;
    int failureCount   = 0;

    logic [7:0] sboxTab[256];
    logic [7:0] invSboxTab[256];

    encryption_core dut (
        .clock            (clock),
        .resetModule      (resetModule),
        .inputData        (inputData),
        .key              (key),
        .inputsLoadedFlag (inputsLoadedFlag),
        .outputData       (outputData),
        .dataEncryptedFlag(dataEncryptedFlag)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    // S-box = affine transform of the multiplicative inverse.
    task automatic buildTables();
        for (int b = 0; b < 256; b++) begin
            logic [7:0] inv, s, bb;
            bb  = 8'(b);
            inv = 8'h00;
            for (int x = 1; x < 256; x++)
                if (bb != 8'h00 && gmul(bb, 8'(x)) == 8'h01) inv = 8'(x);
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sboxTab[b]    = s;
            invSboxTab[s] = bb;
        end
    endtask

    function automatic logic [1407:0] expandKey(input logic [127:0] k);
        logic [7:0] w[176];
        logic [7:0] t0, t1, t2, t3, rc;
        logic [1407:0] ks;
        for (int i = 0; i < 16; i++) w[i] = k[127-8*i -: 8];
        rc = 8'h01;
        for (int i = 16; i < 176; i += 4) begin
            t0 = w[i-4]; t1 = w[i-3]; t2 = w[i-2]; t3 = w[i-1];
            if (i % 16 == 0) begin
                t0 = sboxTab[w[i-3]] ^ rc;
                t1 = sboxTab[w[i-2]];
                t2 = sboxTab[w[i-1]];
                t3 = sboxTab[w[i-4]];
                rc = gmul(rc, 8'h02);
            end
            w[i]   = w[i-16] ^ t0;
            w[i+1] = w[i-15] ^ t1;
            w[i+2] = w[i-14] ^ t2;
            w[i+3] = w[i-13] ^ t3;
        end
        for (int i = 0; i < 176; i++) ks[1407-8*i -: 8] = w[i];
        return ks;
    endfunction

    function automatic logic [127:0] aesEncrypt(input logic [127:0] pt, input logic [127:0] k);
        logic [1407:0] ks;
        logic [7:0] s[16], t[16];
        logic [127:0] res;
        ks = expandKey(k);
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ ks[1407-8*i -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[4*c+r] = sboxTab[s[4*((c+r)%4)+r]];
            for (int c = 0; c < 4; c++) begin
                if (rnd < 10) begin
                    s[4*c]   = gmul(t[4*c], 2) ^ gmul(t[4*c+1], 3) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 2) ^ gmul(t[4*c+2], 3) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 2) ^ gmul(t[4*c+3], 3);
                    s[4*c+3] = gmul(t[4*c], 3) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 2);
                end else begin
                    for (int r = 0; r < 4; r++) s[4*c+r] = t[4*c+r];
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ ks[1407-8*(16*rnd+i) -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    function automatic logic [127:0] aesDecrypt(input logic [127:0] ct, input logic [127:0] k);
        logic [1407:0] ks;
        logic [7:0] s[16], t[16];
        logic [127:0] res;
        ks = expandKey(k);
        for (int i = 0; i < 16; i++) s[i] = ct[127-8*i -: 8] ^ ks[1407-8*(160+i) -: 8];
        for (int rnd = 9; rnd >= 0; rnd--) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[4*c+r] = invSboxTab[s[4*((c-r+4)%4)+r]];
            for (int i = 0; i < 16; i++) t[i] = t[i] ^ ks[1407-8*(16*rnd+i) -: 8];
            for (int c = 0; c < 4; c++) begin
                if (rnd > 0) begin
                    s[4*c]   = gmul(t[4*c], 14) ^ gmul(t[4*c+1], 11) ^ gmul(t[4*c+2], 13) ^ gmul(t[4*c+3], 9);
                    s[4*c+1] = gmul(t[4*c], 9) ^ gmul(t[4*c+1], 14) ^ gmul(t[4*c+2], 11) ^ gmul(t[4*c+3], 13);
                    s[4*c+2] = gmul(t[4*c], 13) ^ gmul(t[4*c+1], 9) ^ gmul(t[4*c+2], 14) ^ gmul(t[4*c+3], 11);
                    s[4*c+3] = gmul(t[4*c], 11) ^ gmul(t[4*c+1], 13) ^ gmul(t[4*c+2], 9) ^ gmul(t[4*c+3], 14);
                end else begin
                    for (int r = 0; r < 4; r++) s[4*c+r] = t[4*c+r];
                end
            end
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        resetModule = 1'b1; inputsLoadedFlag = 1'b0;
        inputData = C1_PT; key = C1_KEY;
        tick(); tick();
        assertionCount++;
        if (outputData !== 128'h0) begin
            failureCount++; $display("[TB] FAIL reset_data: got %h expected %h", outputData, 128'h0);
        end
        assertionCount++;
        if (dataEncryptedFlag !== 1'b0) begin
            failureCount++; $display("[TB] FAIL reset_flag: got %b expected 0", dataEncryptedFlag);
        end
        resetModule = 1'b0;
    endtask

    task automatic test_fips_c1();
        logic [127:0] recovered;
        int holdErrors;
        inputData = C1_PT; key = C1_KEY; inputsLoadedFlag = 1'b1;
        tick();
        for (int cyc = 1; cyc <= 9; cyc++) begin
            tick();
            assertionCount++;
            if (dataEncryptedFlag !== 1'b0) begin
                failureCount++; $display("[TB] FAIL c1_early_flag cycle %0d: got %b expected 0", cyc, dataEncryptedFlag);
            end
        end
        tick();
        assertionCount++;
        if (dataEncryptedFlag !== 1'b1 || outputData !== C1_CT) begin
            failureCount++; $display("[TB] FAIL c1_result: got flag %b data %h expected flag 1 data %h", dataEncryptedFlag, outputData, C1_CT);
        end
        recovered = aesDecrypt(outputData, C1_KEY);
        assertionCount++;
        if (recovered !== C1_PT) begin
            failureCount++; $display("[TB] FAIL c1_round_trip: got %h expected %h", recovered, C1_PT);
        end
        holdErrors = 0;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            tick();
            assertionCount++;
            if ((dataEncryptedFlag !== 1'b1 || outputData !== C1_CT) && holdErrors < 5) begin
                holdErrors++; failureCount++;
                $display("[TB] FAIL c1_hold cycle %0d: got flag %b data %h expected flag 1 data %h", cyc, dataEncryptedFlag, outputData, C1_CT);
            end else if (dataEncryptedFlag !== 1'b1 || outputData !== C1_CT) begin
                failureCount++;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] expected;
        expected = aesEncrypt(B_PT, B_KEY);
        inputsLoadedFlag = 1'b0;
        tick();
        assertionCount++;
        if (dataEncryptedFlag !== 1'b0 || outputData !== C1_CT) begin
            failureCount++; $display("[TB] FAIL b2b_drop: got flag %b data %h expected flag 0 data %h", dataEncryptedFlag, outputData, C1_CT);
        end
        inputData = B_PT; key = B_KEY; inputsLoadedFlag = 1'b1;
        tick();
        for (int cyc = 1; cyc <= 9; cyc++) begin
            tick();
            assertionCount++;
            if (dataEncryptedFlag !== 1'b0 || outputData !== C1_CT) begin
                failureCount++; $display("[TB] FAIL b2b_wait cycle %0d: got flag %b data %h expected flag 0 data %h", cyc, dataEncryptedFlag, outputData, C1_CT);
            end
        end
        tick();
        assertionCount++;
        if (dataEncryptedFlag !== 1'b1 || outputData !== B_CT) begin
            failureCount++; $display("[TB] FAIL appB_result: got flag %b data %h expected flag 1 data %h", dataEncryptedFlag, outputData, B_CT);
        end
        assertionCount++;
        if (outputData !== expected) begin
            failureCount++; $display("[TB] FAIL appB_model: got %h expected %h", outputData, expected);
        end
    endtask

    task automatic test_input_change();
        inputsLoadedFlag = 1'b0;
        tick();
        inputData = C1_PT; key = C1_KEY; inputsLoadedFlag = 1'b1;
        tick();
        for (int cyc = 1; cyc <= 9; cyc++) begin
            tick();
            if (cyc == 3) begin inputData = ALL_ONES; key = ALL_ONES; end
            if (cyc == 4) inputsLoadedFlag = 1'b0;
            if (cyc == 6) inputsLoadedFlag = 1'b1;
            assertionCount++;
            if (dataEncryptedFlag !== 1'b0) begin
                failureCount++; $display("[TB] FAIL change_early_flag cycle %0d: got %b expected 0", cyc, dataEncryptedFlag);
            end
        end
        tick();
        assertionCount++;
        if (dataEncryptedFlag !== 1'b1 || outputData !== C1_CT) begin
            failureCount++; $display("[TB] FAIL change_result: got flag %b data %h expected flag 1 data %h", dataEncryptedFlag, outputData, C1_CT);
        end
    endtask

    task automatic test_reset_mid();
        inputsLoadedFlag = 1'b0;
        tick();
        inputData = C1_PT; key = C1_KEY; inputsLoadedFlag = 1'b1;
        tick();
        for (int cyc = 1; cyc <= 4; cyc++) tick();
        resetModule = 1'b1;
        tick();
        assertionCount++;
        if (dataEncryptedFlag !== 1'b0 || outputData !== 128'h0) begin
            failureCount++; $display("[TB] FAIL mid_reset: got flag %b data %h expected flag 0 data 0", dataEncryptedFlag, outputData);
        end
        resetModule = 1'b0;
        tick();
        for (int cyc = 1; cyc <= 9; cyc++) begin
            tick();
            assertionCount++;
            if (dataEncryptedFlag !== 1'b0 || outputData !== 128'h0) begin
                failureCount++; $display("[TB] FAIL post_reset_wait cycle %0d: got flag %b data %h expected flag 0 data 0", cyc, dataEncryptedFlag, outputData);
            end
        end
        tick();
        assertionCount++;
        if (dataEncryptedFlag !== 1'b1 || outputData !== C1_CT) begin
            failureCount++; $display("[TB] FAIL post_reset_result: got flag %b data %h expected flag 1 data %h", dataEncryptedFlag, outputData, C1_CT);
        end
    endtask

    task automatic test_random();
        logic [127:0] pt, k, expected, previous;
        previous = C1_CT;
        for (int n = 0; n < 6; n++) begin
            pt = {$urandom, $urandom, $urandom, $urandom};
            k  = {$urandom, $urandom, $urandom, $urandom};
            expected = aesEncrypt(pt, k);
            inputsLoadedFlag = 1'b0;
            tick();
            inputData = pt; key = k; inputsLoadedFlag = 1'b1;
            tick();
            for (int cyc = 1; cyc <= 9; cyc++) tick();
            assertionCount++;
            if (dataEncryptedFlag !== 1'b0 || outputData !== previous) begin
                failureCount++; $display("[TB] FAIL random_%0d_before: got flag %b data %h expected flag 0 data %h", n, dataEncryptedFlag, outputData, previous);
            end
            tick();
            assertionCount++;
            if (dataEncryptedFlag !== 1'b1 || outputData !== expected) begin
                failureCount++; $display("[TB] FAIL random_%0d_result: got flag %b data %h expected flag 1 data %h", n, dataEncryptedFlag, outputData, expected);
            end
            previous = expected;
        end
    endtask

    initial begin
        resetModule = 1'b1; inputsLoadedFlag = 1'b0;
        inputData = '0; key = '0;
        buildTables();
        test_reset();
        test_fips_c1();
        test_back_to_back();
        test_input_change();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", assertionCount, failureCount);
        $finish;
    end

endmodule
